// File: rtl/bram32_arbiter.sv
// Two-port arbiter sharing one single-port 32-bit block RAM between fetch (m0) and load/store (m1).
// Define BRAM_ARB_RR_EN for round-robin tie-breaking; otherwise m1 has fixed priority on ties.
module bram32_arbiter #(
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        m0_req,
  input  logic [15:0] m0_a,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_a,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [15:0] bram_a,
  output logic [31:0] bram_do,
  output logic        bram_we,
  input  logic [31:0] bram_di
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [15:0] bram_a_q, bram_a_d;
  logic [31:0] bram_do_q, bram_do_d;
  logic        bram_we_q, bram_we_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        elig0_s, elig1_s, any_s, win1_s, load_s;
`ifdef BRAM_ARB_RR_EN
  logic        last_q;
`endif

  function automatic logic [15:0] fold_addr(input logic [15:0] a);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i < adr_width) r[i] = a[i];
      else               r[i] = 1'b0;
    end
    return r;
  endfunction

  // Eligibility and winner selection; the port acked this cycle sits out one round.
  always_comb begin
    elig0_s = m0_req & ~((state_q == ST_RESP) & m0_ack_q);
    elig1_s = m1_req & ~((state_q == ST_RESP) & m1_ack_q);
    any_s   = elig0_s | elig1_s;
`ifdef BRAM_ARB_RR_EN
    if (elig0_s && elig1_s) win1_s = ~last_q;
    else                    win1_s = elig1_s;
`else
    win1_s  = elig1_s;
`endif
  end

  // Next-state, RAM-port and response logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    bram_a_d   = bram_a_q;
    bram_do_d  = bram_do_q;
    bram_we_d  = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    load_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          load_s  = 1'b1;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        m0_ack_d = ~gnt_q;
        m1_ack_d = gnt_q;
      end
      ST_RESP: begin
        if (m0_ack_q)      m0_rdata_d = bram_di;
        else if (m1_ack_q) m1_rdata_d = bram_di;
        else               m0_rdata_d = m0_rdata_q;
        if (any_s) begin
          load_s  = 1'b1;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // m0 never writes, so its grants carry zero write data.
    if (load_s) begin
      gnt_d     = win1_s;
      bram_a_d  = fold_addr(win1_s ? m1_a : m0_a);
      bram_do_d = win1_s ? m1_wdata : 32'h0000_0000;
      bram_we_d = win1_s & m1_we;
    end else begin
      gnt_d     = gnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      bram_a_q   <= 16'h0000;
      bram_do_q  <= 32'h0000_0000;
      bram_we_q  <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0000_0000;
      m1_rdata_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      bram_a_q   <= bram_a_d;
      bram_do_q  <= bram_do_d;
      bram_we_q  <= bram_we_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

`ifdef BRAM_ARB_RR_EN
  // Most-recently-granted pointer; 0 = m0, so m1 wins the first tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_q <= 1'b0;
    end else if (load_s) begin
      last_q <= win1_s;
    end else begin
      last_q <= last_q;
    end
  end
`endif

  // RAM data arrives in the ack cycle itself, so it is forwarded then and held afterwards.
  assign m0_rdata = m0_ack_q ? bram_di : m0_rdata_q;
  assign m1_rdata = m1_ack_q ? bram_di : m1_rdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign bram_a   = bram_a_q;
  assign bram_do  = bram_do_q;
  assign bram_we  = bram_we_q;

endmodule

// File: doc/bram32_arbiter.md
# bram32_arbiter

Two-port arbiter that shares one single-port 32-bit block RAM between the instruction-fetch port (m0, read-only) and the load/store port (m1, read/write). It drives the RAM's address, write-data and write-enable pins from registers and returns the RAM's one-cycle-latency read data to the granted requester with a one-cycle acknowledge. It sits between the CPU core's memory ports and the bram32 instance.

## Interface
- adr_width, 11: byte-address bits the RAM decodes; also the width of the bram_a bits that are forwarded.
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- m0_req  in  1  fetch request, held high until m0_ack
- m0_a  in  16  fetch byte address, stable while m0_req
- m0_ack  out  1  one-cycle pulse, m0_rdata valid
- m0_rdata  out  32  fetch read data
- m1_req  in  1  load/store request, held high until m1_ack
- m1_we  in  1  1 = write, 0 = read; stable while m1_req
- m1_a  in  16  load/store byte address
- m1_wdata  in  32  write data
- m1_ack  out  1  one-cycle pulse; read: m1_rdata valid; write: completed
- m1_rdata  out  32  load data (for writes: previous RAM contents)
- bram_a  out  16  RAM address, registered
- bram_do  out  32  RAM write data, registered
- bram_we  out  1  RAM write enable, registered
- bram_di  in  32  RAM read data, valid one cycle after address

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any eligible request, pick winner, load bram_a/bram_do/bram_we from winner, go ACCESS; else stay.
- ACCESS: RAM samples address (and write) at end of cycle; bram_we deasserts on leaving; go RESP.
- RESP: pulse winner's ack, present bram_di on winner's rdata (rdata registered = bram_di, held until next ack of that port). Simultaneously arbitrate among eligible requests; if one wins, load RAM registers and go ACCESS, else IDLE.
- Eligible: req high, excluding the port being acked in the current RESP cycle.
- m0 is never a writer: bram_we = 0 for m0 grants; bram_do = 0.
- bram_a = winner address with bits [15:adr_width] forced to 0.
- Writes are read-first: m1_rdata on a write ack = RAM word before the write.
- Only one ack asserted per cycle; a port's ack never asserts without its req.

## Timing
- Reset (async, immediate): state IDLE; m0_ack, m1_ack, bram_we = 0; bram_a, bram_do, m0_rdata, m1_rdata = 0; RR pointer = m0 last-granted.
- Req at cycle N from IDLE: ACCESS N+1, ack N+2 (3-cycle latency from req to ack).
- Back-to-back alternating ports: one access per 2 cycles (RESP overlaps next grant).
- Same port re-requesting after ack: passes through IDLE, 3 cycles per access.
- Simultaneous m0/m1 requests in IDLE: resolved per Configuration.
- req dropped before ack: protocol violation; transaction still completes and acks.
- Reset mid-ACCESS: bram_we cleared asynchronously; no ack; pending write suppressed if reset asserts before the ACCESS clock edge.

## Configuration
- BRAM_ARB_RR_EN defined: round-robin; on a tie the port not most recently granted wins; pointer updates on every grant.
- Undefined: fixed priority, m1 beats m0 on ties. The RESP exclusion rule still prevents either port starving the other while both hold req.

## Test plan
- After reset, all outputs 0; m0_req with m0_a = 0x0010, RAM word 4 = 0xDEADBEEF -> bram_a = 0x0010 at N+1, m0_ack and m0_rdata = 0xDEADBEEF at N+2.
- m1 write m1_a = 0x0020, wdata = 0x12345678 over old 0xAAAA5555 -> bram_we high exactly one cycle, m1_ack at N+2 with m1_rdata = 0xAAAA5555; later m0 read of 0x0020 returns 0x12345678.
- m0 and m1 requesting together from IDLE, continuously -> acks alternate every 2 cycles; first winner m1 (both configurations).
- m1_a = 0xF804 with adr_width = 11 -> bram_a = 0x0004.
- sys_rst_n low during ACCESS of a write -> bram_we drops immediately, no ack, RAM word unchanged, FSM IDLE after release.
